// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//   Multi-cycle fetch/decode/execute controller for the pocket-calculator CPU.
//   It drives instruction fetch, the IR load, PC update, the ALU start/done
//   handshake, data/stack memory access and accumulator write-back.
//
//   State table:
//     state    | meaning
//     FETCH    | read instruction at PC, load IR and bump PC on mem_rdy
//     DECODE   | one idle cycle while the opcode class is resolved
//     EXEC     | branch PC load, or single-cycle ALU start
//     ALU_WAIT | wait for alu_done
//     MEM      | data/stack memory access for LOAD/STORE/PUSH/POP
//     WB       | accumulator write enable for one cycle
//     HALT     | core stopped until reset (error flag tells why)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   opcode     IR[15:10], valid from DECODE onward
//   flag_z     accumulator zero flag
//   flag_n     accumulator negative flag
//   mem_rdy    memory access complete (pulse or held)
//   alu_done   ALU result valid
//   ir_en      instruction register load enable
//   pc_inc     PC += 1
//   pc_ld      PC <= BA
//   addr_sel   memory address source: 0 = PC, 1 = BA, 2 = SP
//   mem_rd     memory read request
//   mem_wr     memory write request
//   alu_start  single-cycle ALU start pulse
//   acc_we     accumulator write enable
//   sp_inc     stack pointer increment
//   sp_dec     stack pointer decrement
//   halted     core stopped
//   error      sticky: timeout or illegal opcode
//   state      current state encoding, for debug

module instruction_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       flag_z,
    input  logic       flag_n,
    input  logic       mem_rdy,
    input  logic       alu_done,
    output logic       ir_en,
    output logic       pc_inc,
    output logic       pc_ld,
    output logic [1:0] addr_sel,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       alu_start,
    output logic       acc_we,
    output logic       sp_inc,
    output logic       sp_dec,
    output logic       halted,
    output logic       error,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_ALU_WAIT = 3'd3,
        S_MEM      = 3'd4,
        S_WB       = 3'd5,
        S_HALT     = 3'd6
    } state_t;

    localparam logic [5:0] OP_HLT   = 6'b000000;
    localparam logic [5:0] OP_LOAD  = 6'b000001;
    localparam logic [5:0] OP_STORE = 6'b000010;
    localparam logic [5:0] OP_BRA   = 6'b000011;
    localparam logic [5:0] OP_BRZ   = 6'b000100;
    localparam logic [5:0] OP_BRN   = 6'b000101;
    localparam logic [5:0] OP_PUSH  = 6'b000110;
    localparam logic [5:0] OP_POP   = 6'b000111;
    localparam logic [5:0] OP_NOP   = 6'b001000;

    localparam logic [1:0] SEL_PC = 2'd0;
    localparam logic [1:0] SEL_BA = 2'd1;
    localparam logic [1:0] SEL_SP = 2'd2;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             error_q;
    logic             error_set;
    logic             waiting;
    logic             timed_out;

    logic             is_alu;
    logic             is_branch;
    logic             is_mem;
    logic             br_taken;

    // Raw decoded strobes, forced low while reset is held.
    logic       ir_en_c, pc_inc_c, pc_ld_c, mem_rd_c, mem_wr_c;
    logic       alu_start_c, acc_we_c, sp_inc_c, sp_dec_c;
    logic [1:0] addr_sel_c;

    // MEM-state access descriptor derived from the opcode.
    logic       m_rd, m_wr, m_spi, m_spd, m_legal;
    logic [1:0] m_sel;
    state_t     m_next;

    assign is_alu    = (opcode[5:4] == 2'b01);
    assign is_branch = (opcode == OP_BRA) || (opcode == OP_BRZ) || (opcode == OP_BRN);
    assign is_mem    = (opcode == OP_LOAD) || (opcode == OP_STORE) ||
                       (opcode == OP_PUSH) || (opcode == OP_POP);
    assign br_taken  = (opcode == OP_BRA) ||
                       ((opcode == OP_BRZ) && flag_z) ||
                       ((opcode == OP_BRN) && flag_n);

    // The counter can hold TIMEOUT itself; the timeout decision is made in
    // the cycle that observes it, so a handshake in that cycle still wins.
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT));
    assign waiting   = (state_q == S_FETCH) || (state_q == S_MEM) || (state_q == S_ALU_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (waiting) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (error_set) begin
                error_q <= 1'b1;
            end
        end
    end

    always_comb begin
        m_rd    = 1'b0;
        m_wr    = 1'b0;
        m_spi   = 1'b0;
        m_spd   = 1'b0;
        m_legal = 1'b1;
        m_sel   = SEL_PC;
        m_next  = S_FETCH;
        case (opcode)
            OP_LOAD: begin
                m_sel  = SEL_BA;
                m_rd   = 1'b1;
                m_next = S_WB;
            end
            OP_STORE: begin
                m_sel  = SEL_BA;
                m_wr   = 1'b1;
            end
            OP_PUSH: begin
                m_sel  = SEL_SP;
                m_wr   = 1'b1;
                m_spd  = 1'b1;
            end
            // SP points at the next free slot; the memory map resolves the
            // pre-increment read address for POP.
            OP_POP: begin
                m_sel  = SEL_SP;
                m_rd   = 1'b1;
                m_spi  = 1'b1;
                m_next = S_WB;
            end
            default: m_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        error_set   = 1'b0;
        ir_en_c     = 1'b0;
        pc_inc_c    = 1'b0;
        pc_ld_c     = 1'b0;
        mem_rd_c    = 1'b0;
        mem_wr_c    = 1'b0;
        alu_start_c = 1'b0;
        acc_we_c    = 1'b0;
        sp_inc_c    = 1'b0;
        sp_dec_c    = 1'b0;
        addr_sel_c  = SEL_PC;
        halted      = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (mem_rdy) begin
                    mem_rd_c = 1'b1;
                    ir_en_c  = 1'b1;
                    pc_inc_c = 1'b1;
                    state_d  = S_DECODE;
                end else if (timed_out) begin
                    state_d   = S_HALT;
                    error_set = 1'b1;
                end else begin
                    mem_rd_c = 1'b1;
                end
            end

            S_DECODE: begin
                if (opcode == OP_HLT) begin
                    state_d = S_HALT;
                end else if (is_mem) begin
                    state_d = S_MEM;
                end else if (is_branch || is_alu) begin
                    state_d = S_EXEC;
                end else if (opcode == OP_NOP) begin
                    state_d = S_FETCH;
                end else begin
                    state_d   = S_HALT;
                    error_set = 1'b1;
                end
            end

            S_EXEC: begin
                if (is_branch) begin
                    pc_ld_c = br_taken;
                    state_d = S_FETCH;
                end else if (is_alu) begin
                    alu_start_c = 1'b1;
                    state_d     = S_ALU_WAIT;
                end else begin
                    // Opcode changed under us after DECODE.
                    state_d   = S_HALT;
                    error_set = 1'b1;
                end
            end

            S_ALU_WAIT: begin
                if (alu_done) begin
                    state_d = S_WB;
                end else if (timed_out) begin
                    state_d   = S_HALT;
                    error_set = 1'b1;
                end
            end

            S_MEM: begin
                if (!m_legal || (timed_out && !mem_rdy)) begin
                    state_d   = S_HALT;
                    error_set = 1'b1;
                end else begin
                    addr_sel_c = m_sel;
                    mem_rd_c   = m_rd;
                    mem_wr_c   = m_wr;
                    if (mem_rdy) begin
                        sp_inc_c = m_spi;
                        sp_dec_c = m_spd;
                        state_d  = m_next;
                    end
                end
            end

            S_WB: begin
                acc_we_c = 1'b1;
                state_d  = S_FETCH;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d   = S_HALT;
                error_set = 1'b1;
            end
        endcase
    end

    // State already reads FETCH during reset; masking keeps FETCH's read
    // request from leaking out in the reset cycle.
    assign ir_en     = ir_en_c     & ~reset;
    assign pc_inc    = pc_inc_c    & ~reset;
    assign pc_ld     = pc_ld_c     & ~reset;
    assign mem_rd    = mem_rd_c    & ~reset;
    assign mem_wr    = mem_wr_c    & ~reset;
    assign alu_start = alu_start_c & ~reset;
    assign acc_we    = acc_we_c    & ~reset;
    assign sp_inc    = sp_inc_c    & ~reset;
    assign sp_dec    = sp_dec_c    & ~reset;
    assign addr_sel  = reset ? SEL_PC : addr_sel_c;
    assign error     = error_q;
    assign state     = state_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
module tb_instruction_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       flag_z, flag_n, mem_rdy, alu_done;
    logic       ir_en, pc_inc, pc_ld, mem_rd, mem_wr, alu_start, acc_we, sp_inc, sp_dec;
    logic       halted, error;
    logic [1:0] addr_sel;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_AW = 3'd3,
                           ST_M = 3'd4, ST_WB = 3'd5, ST_H = 3'd6;

    // Strobe vector bit order: ir_en pc_inc pc_ld mem_rd mem_wr alu_start acc_we sp_inc sp_dec
    localparam logic [8:0] IR  = 9'h100, PCI = 9'h080, PCL = 9'h040, RD = 9'h020,
                           WR  = 9'h010, AS  = 9'h008, WE  = 9'h004, SPI = 9'h002,
                           SPD = 9'h001, NONE = 9'h000;

    instruction_sequencer #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .flag_z(flag_z), .flag_n(flag_n),
        .mem_rdy(mem_rdy), .alu_done(alu_done), .ir_en(ir_en), .pc_inc(pc_inc),
        .pc_ld(pc_ld), .addr_sel(addr_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .alu_start(alu_start), .acc_we(acc_we), .sp_inc(sp_inc), .sp_dec(sp_dec),
        .halted(halted), .error(error), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (state,halted,error,addr_sel,strobes)", tag, got, exp);
        end
    endtask

    // Inputs are already set (posedge+1); sample at the falling edge, then
    // advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [8:0] stb,
                       input logic [1:0] as, input logic h, input logic e);
        @(negedge clk);
        chk(tag, {state, halted, error, addr_sel,
                  ir_en, pc_inc, pc_ld, mem_rd, mem_wr, alu_start, acc_we, sp_inc, sp_dec},
                 {st, h, e, as, stb});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input string tag, input logic [5:0] op);
        opcode  = op;
        mem_rdy = 1'b1;
        cyc({tag, "_fetch"}, ST_F, RD | IR | PCI, 2'd0, 1'b0, 1'b0);
        mem_rdy = 1'b0;
        cyc({tag, "_decode"}, ST_D, NONE, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc("reset_hold", ST_F, NONE, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; opcode = 6'd0; flag_z = 0; flag_n = 0; mem_rdy = 0; alu_done = 0;
        cyc("por", ST_F, NONE, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc("fetch_idle", ST_F, RD, 2'd0, 1'b0, 1'b0);

        // ALU op, ALU_DONE in EXEC is ignored, real done after two idle waits
        fetch_decode("alu", 6'b011010);
        alu_done = 1'b1;
        cyc("alu_exec", ST_E, AS, 2'd0, 1'b0, 1'b0);
        alu_done = 1'b0;
        cyc("alu_wait1", ST_AW, NONE, 2'd0, 1'b0, 1'b0);
        cyc("alu_wait2", ST_AW, NONE, 2'd0, 1'b0, 1'b0);
        alu_done = 1'b1;
        cyc("alu_wait3", ST_AW, NONE, 2'd0, 1'b0, 1'b0);
        alu_done = 1'b0;
        cyc("alu_wb", ST_WB, WE, 2'd0, 1'b0, 1'b0);
        cyc("alu_back", ST_F, RD, 2'd0, 1'b0, 1'b0);

        // Reset in the middle of ALU_WAIT
        fetch_decode("rst", 6'b010001);
        cyc("rst_exec", ST_E, AS, 2'd0, 1'b0, 1'b0);
        cyc("rst_wait", ST_AW, NONE, 2'd0, 1'b0, 1'b0);
        do_reset();
        cyc("rst_release", ST_F, RD, 2'd0, 1'b0, 1'b0);

        // LOAD with 4 wait cycles
        fetch_decode("load", 6'b000001);
        for (int i = 0; i < 4; i++) cyc("load_wait", ST_M, RD, 2'd1, 1'b0, 1'b0);
        mem_rdy = 1'b1;
        cyc("load_rdy", ST_M, RD, 2'd1, 1'b0, 1'b0);
        mem_rdy = 1'b0;
        cyc("load_wb", ST_WB, WE, 2'd0, 1'b0, 1'b0);

        // Branches
        flag_z = 1'b1;
        fetch_decode("brz_t", 6'b000100);
        cyc("brz_taken", ST_E, PCL, 2'd0, 1'b0, 1'b0);
        flag_z = 1'b0;
        fetch_decode("brz_n", 6'b000100);
        cyc("brz_not", ST_E, NONE, 2'd0, 1'b0, 1'b0);
        fetch_decode("bra", 6'b000011);
        cyc("bra_taken", ST_E, PCL, 2'd0, 1'b0, 1'b0);
        flag_n = 1'b1;
        fetch_decode("brn_t", 6'b000101);
        cyc("brn_taken", ST_E, PCL, 2'd0, 1'b0, 1'b0);
        flag_n = 1'b0;

        // STORE, PUSH, POP
        fetch_decode("store", 6'b000010);
        cyc("store_wait", ST_M, WR, 2'd1, 1'b0, 1'b0);
        mem_rdy = 1'b1;
        cyc("store_rdy", ST_M, WR, 2'd1, 1'b0, 1'b0);
        mem_rdy = 1'b0;
        fetch_decode("push", 6'b000110);
        cyc("push_wait", ST_M, WR, 2'd2, 1'b0, 1'b0);
        mem_rdy = 1'b1;
        cyc("push_rdy", ST_M, WR | SPD, 2'd2, 1'b0, 1'b0);
        mem_rdy = 1'b0;
        fetch_decode("pop", 6'b000111);
        mem_rdy = 1'b1;
        cyc("pop_rdy", ST_M, RD | SPI, 2'd2, 1'b0, 1'b0);
        mem_rdy = 1'b0;
        cyc("pop_wb", ST_WB, WE, 2'd0, 1'b0, 1'b0);

        // NOP returns straight to a fresh FETCH; then handshake wins at the limit
        fetch_decode("nop", 6'b001000);
        for (int i = 0; i < 16; i++) cyc("edge_wait", ST_F, RD, 2'd0, 1'b0, 1'b0);
        opcode  = 6'b001000;
        mem_rdy = 1'b1;
        cyc("edge_rdy_wins", ST_F, RD | IR | PCI, 2'd0, 1'b0, 1'b0);
        mem_rdy = 1'b0;
        cyc("edge_decode", ST_D, NONE, 2'd0, 1'b0, 1'b0);

        // Fetch timeout
        for (int i = 0; i < 16; i++) cyc("to_wait", ST_F, RD, 2'd0, 1'b0, 1'b0);
        cyc("to_fire", ST_F, NONE, 2'd0, 1'b0, 1'b0);
        cyc("to_halt", ST_H, NONE, 2'd0, 1'b1, 1'b1);
        mem_rdy = 1'b1; alu_done = 1'b1;
        cyc("to_halt_hold", ST_H, NONE, 2'd0, 1'b1, 1'b1);
        mem_rdy = 1'b0; alu_done = 1'b0;
        do_reset();

        // Illegal opcode
        fetch_decode("illegal", 6'b111111);
        cyc("illegal_halt", ST_H, NONE, 2'd0, 1'b1, 1'b1);
        cyc("illegal_hold", ST_H, NONE, 2'd0, 1'b1, 1'b1);
        do_reset();

        // HLT
        fetch_decode("hlt", 6'b000000);
        cyc("hlt_halt", ST_H, NONE, 2'd0, 1'b1, 1'b0);
        cyc("hlt_hold", ST_H, NONE, 2'd0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
